// File: rtl/fdivsqrt_intpreproc_seq.sv
// fdivsqrt_intpreproc_seq: sequential integer-divide preprocessor (abs, lzc normalise, digit alignment)
module fdivsqrt_intpreproc_seq #(
  parameter int XLEN = 64,
  parameter int LOGR = 1,
  parameter int K = 1,
  parameter int SHSTEP = 8,
  parameter int LW = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [XLEN-1:0]   A,
  input  logic [XLEN-1:0]   B,
  input  logic              Signed,
  input  logic              W64,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [XLEN+3:0]   X,
  output logic [XLEN+3:0]   D,
  output logic [LW-1:0]     nE,
  output logic [LW-1:0]     ell,
  output logic [LW-1:0]     m,
  output logic              NegQuot,
  output logic              As,
  output logic              BZero,
  output logic              ALTB,
  output logic              SpecialCase,
  output logic [XLEN-1:0]   AOut
);
  localparam int RK = LOGR * K;
  localparam logic [LW-1:0] STEP = LW'(SHSTEP);
  typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] ae, be, pos_a, pos_b;
  logic [LW-1:0] lz_a, lz_b, rem_a, rem_b, sa, sb;
  logic [LW:0] zd, zdiff, p, t, rs;
  logic [LW+1:0] steps;
  logic as_c, bs_c, bz_c, res_v;

  function automatic logic [LW-1:0] lzc(input logic [XLEN-1:0] v);
    lzc = LW'(XLEN);
    for (int i = 0; i < XLEN; i++)
      if (v[i]) lzc = LW'(XLEN - 1 - i);
  endfunction

  generate
    if (XLEN == 64) begin : g_w64
      assign ae = W64 ? {{32{A[31] & Signed}}, A[31:0]} : A;
      assign be = W64 ? {{32{B[31] & Signed}}, B[31:0]} : B;
    end else begin : g_nw64
      assign ae = A;
      assign be = B;
    end
  endgenerate

  assign as_c = ae[XLEN-1] & Signed;
  assign bs_c = be[XLEN-1] & Signed;
  assign lz_a = lzc(pos_a);
  assign lz_b = lzc(pos_b);
  assign zd = {1'b0, lz_b} - {1'b0, lz_a};
  assign bz_c = pos_b == '0;
  assign sa = rem_a > STEP ? STEP : rem_a;
  assign sb = rem_b > STEP ? STEP : rem_b;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = InValid ? ABS : IDLE;
      ABS:     state_n = (bz_c | zd[LW] | ((lz_a | lz_b) == '0)) ? DONE : SHIFT;
      SHIFT:   state_n = (rem_a <= STEP && rem_b <= STEP) ? DONE : SHIFT;
      DONE:    state_n = OutReady ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
    if (Flush) state_n = IDLE;
  end

  always_comb begin
    InReady = state == IDLE;
    OutValid = state == DONE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pos_a <= '0;
      pos_b <= '0;
      AOut <= '0;
      As <= 1'b0;
      NegQuot <= 1'b0;
      ell <= '0;
      m <= '0;
      rem_a <= '0;
      rem_b <= '0;
      zdiff <= '0;
      ALTB <= 1'b0;
      BZero <= 1'b0;
      SpecialCase <= 1'b0;
      res_v <= 1'b0;
    end else if (state == IDLE && InValid && !Flush) begin
      AOut <= ae;
      As <= as_c;
      NegQuot <= as_c ^ bs_c;
      pos_a <= as_c ? -ae : ae;
      pos_b <= bs_c ? -be : be;
      res_v <= 1'b1;
    end else if (state == ABS) begin
      ell <= lz_a;
      m <= lz_b;
      rem_a <= lz_a;
      rem_b <= lz_b;
      zdiff <= zd;
      ALTB <= zd[LW];
      BZero <= bz_c;
      SpecialCase <= bz_c | zd[LW];
    end else if (state == SHIFT) begin
      pos_a <= pos_a << sa;
      pos_b <= pos_b << sb;
      rem_a <= rem_a - sa;
      rem_b <= rem_b - sb;
    end

  // res_v keeps nE at zero until the first operand pair has been taken
  always_comb begin
    p = ALTB ? '0 : zdiff;
    t = p + (LW+1)'(LOGR);
    steps = ({1'b0, t} + (LW+2)'(RK - 1)) >> $clog2(RK);
    rs = (LW+1)'(RK - 1) - ((t - (LW+1)'(1)) & (LW+1)'(RK - 1));
    nE = (res_v & ~SpecialCase) ? LW'(steps * K - 1) : '0;
    X = SpecialCase ? {4'b0000, pos_a} : {4'b0000, pos_a} >> rs;
    D = {4'b0000, pos_b};
  end
endmodule
